// File: rtl/quick_spi_scheduler.sv
// Round-robin scheduler that shares one SPI transfer engine between several clients.
// Each grant runs one engine transaction, returns RX data or an error, then waits a slave-select gap.
module quick_spi_scheduler #(
  parameter int NUM_REQUESTERS   = 4,
  parameter int NUMBER_OF_SLAVES = 2,
  parameter int SLAVE_BITS       = 3,
  parameter int DATA_WIDTH       = 32,
  parameter int NBITS_WIDTH      = 6,
  parameter int GAP_CYCLES       = 4,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                                   s_axi_aclk,
  input  logic                                   s_axi_areset,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  input  logic [NUM_REQUESTERS*SLAVE_BITS-1:0]   req_slave,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQUESTERS*NBITS_WIDTH-1:0]  req_nbits,
  output logic [NUM_REQUESTERS-1:0]              resp_valid,
  input  logic [NUM_REQUESTERS-1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]                  resp_data,
  output logic                                   resp_err,
  output logic                                   eng_start,
  output logic [SLAVE_BITS-1:0]                  eng_slave,
  output logic [DATA_WIDTH-1:0]                  eng_data,
  output logic [NBITS_WIDTH-1:0]                 eng_nbits,
  input  logic                                   eng_busy,
  input  logic                                   eng_done,
  input  logic [DATA_WIDTH-1:0]                  eng_rx_data,
  output logic [2:0]                             gnt_id,
  output logic                                   busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND,
    GAP
  } state_t;

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [2:0]  PTR_RESET = 3'(NUM_REQUESTERS - 1);
  localparam logic [NUM_REQUESTERS-1:0] ONE_HOT0 = NUM_REQUESTERS'(1);

  state_t                    state, state_d;
  logic [2:0]                rr_ptr, rr_ptr_d;
  logic [2:0]                gnt_id_d;
  logic [SLAVE_BITS-1:0]     eng_slave_d;
  logic [DATA_WIDTH-1:0]     eng_data_d;
  logic [NBITS_WIDTH-1:0]    eng_nbits_d;
  logic                      eng_start_d;
  logic [NUM_REQUESTERS-1:0] resp_valid_d;
  logic [DATA_WIDTH-1:0]     resp_data_d;
  logic                      resp_err_d;
  logic [15:0]               to_cnt, to_cnt_d;
  logic [15:0]               gap_cnt, gap_cnt_d;

  logic                      win_found;
  logic [2:0]                winner;
  logic [NUM_REQUESTERS-1:0] win_onehot;
  logic [NUM_REQUESTERS-1:0] gnt_onehot;
  logic [SLAVE_BITS-1:0]     sel_slave;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic [NBITS_WIDTH-1:0]    sel_nbits;
  logic                      sel_invalid;
  logic                      resp_accept;

  // Search starts just past the last winner, so the previous grantee has lowest priority.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int o = 1; o <= NUM_REQUESTERS; o++) begin
      for (int j = 0; j < NUM_REQUESTERS; j++) begin
        if (!win_found && req_valid[j] && ((int'(rr_ptr) + o) % NUM_REQUESTERS) == j) begin
          win_found = 1'b1;
          winner    = 3'(j);
        end
      end
    end
  end

  always_comb begin
    sel_slave = '0;
    sel_data  = '0;
    sel_nbits = '0;
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      if (3'(j) == winner) begin
        sel_slave = req_slave[j*SLAVE_BITS +: SLAVE_BITS];
        sel_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
        sel_nbits = req_nbits[j*NBITS_WIDTH +: NBITS_WIDTH];
      end
    end
    sel_invalid = (sel_nbits == '0) ||
                  (int'(sel_nbits) > DATA_WIDTH) ||
                  (int'(sel_slave) >= NUMBER_OF_SLAVES);
  end

  assign win_onehot  = ONE_HOT0 << winner;
  assign gnt_onehot  = ONE_HOT0 << gnt_id;
  assign resp_accept = |(resp_ready & resp_valid);
  assign busy        = (state != IDLE);

  // Held low during reset so a client cannot see a grant that will never complete.
  assign req_ready = (state == IDLE && win_found && !s_axi_areset) ? win_onehot : '0;

  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    gnt_id_d     = gnt_id;
    eng_slave_d  = eng_slave;
    eng_data_d   = eng_data;
    eng_nbits_d  = eng_nbits;
    eng_start_d  = 1'b0;
    resp_valid_d = resp_valid;
    resp_data_d  = resp_data;
    resp_err_d   = resp_err;
    to_cnt_d     = to_cnt;
    gap_cnt_d    = gap_cnt;

    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_id_d    = winner;
          rr_ptr_d    = winner;
          eng_slave_d = sel_slave;
          eng_data_d  = sel_data;
          eng_nbits_d = sel_nbits;
          if (sel_invalid) begin
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = win_onehot;
            state_d      = RESPOND;
          end else begin
            eng_start_d = !eng_busy;
            state_d     = ISSUE;
          end
        end
      end

      // The start pulse is launched from here; once it has been seen high we move on.
      ISSUE: begin
        if (eng_start) begin
          to_cnt_d = '0;
          state_d  = WAIT_DONE;
        end else if (!eng_busy) begin
          eng_start_d = 1'b1;
        end
      end

      WAIT_DONE: begin
        if (eng_done) begin
          resp_data_d  = eng_rx_data;
          resp_err_d   = 1'b0;
          resp_valid_d = gnt_onehot;
          state_d      = RESPOND;
        end else if (to_cnt == TO_LAST) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = gnt_onehot;
          state_d      = RESPOND;
        end else begin
          to_cnt_d = to_cnt + 16'd1;
        end
      end

      RESPOND: begin
        if (resp_accept) begin
          resp_valid_d = '0;
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state      <= IDLE;
      rr_ptr     <= PTR_RESET;
      gnt_id     <= '0;
      eng_slave  <= '0;
      eng_data   <= '0;
      eng_nbits  <= '0;
      eng_start  <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      gnt_id     <= gnt_id_d;
      eng_slave  <= eng_slave_d;
      eng_data   <= eng_data_d;
      eng_nbits  <= eng_nbits_d;
      eng_start  <= eng_start_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      to_cnt     <= to_cnt_d;
      gap_cnt    <= gap_cnt_d;
    end
  end

endmodule
